// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants and fetch-stage control types.
// Imported by the fetch stage, its pipeline flops and the bus interface.
package mips_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;

    localparam int unsigned OP_MSB    = 31;
    localparam int unsigned OP_LSB    = 26;
    localparam int unsigned FUNCT_MSB = 5;
    localparam int unsigned FUNCT_LSB = 0;

    localparam int unsigned CNT_WIDTH = 32;

    // Action taken by the IF/ID register on a given edge (reset is handled by the flops).
    typedef enum logic [1:0] {
        IFID_CAPTURE = 2'b00,
        IFID_HOLD    = 2'b01,
        IFID_FLUSH   = 2'b10
    } ifid_action_e;

    // Source of the next fetch PC.
    typedef enum logic [1:0] {
        NPC_INC      = 2'b00,
        NPC_HOLD     = 2'b01,
        NPC_REDIRECT = 2'b10
    } npc_sel_e;

endpackage : mips_pkg

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: imem address/data, hazard/branch controls in, Decode-side outputs.
// master = the fetch stage itself, slave = the surrounding pipeline and memory.
interface fetch_stage_if #(
    parameter int WIDTH = 32
);
    import mips_pkg::*;

    logic [WIDTH-1:0]     instr_i;
    logic                 stall;
    logic                 redirect;
    logic [WIDTH-1:0]     redirect_target;
    logic [WIDTH-1:0]     pcF;
    logic [WIDTH-1:0]     instrD;
    logic [WIDTH-1:0]     pcplus4D;
    logic [5:0]           opD;
    logic [5:0]           functD;
    logic                 validD;
    logic [CNT_WIDTH-1:0] fetch_cnt;

    modport master (
        input  instr_i, stall, redirect, redirect_target,
        output pcF, instrD, pcplus4D, opD, functD, validD, fetch_cnt
    );

    modport slave (
        output instr_i, stall, redirect, redirect_target,
        input  pcF, instrD, pcplus4D, opD, functD, validD, fetch_cnt
    );

endinterface : fetch_stage_if

// File: rtl/flopenrc.sv
// Parameterised register with synchronous reset, active-high enable and synchronous clear.
// Priority: reset > enable-low hold > clear > load.
module flopenrc #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    // NOTE: q_d is given its hold value first so every path assigns it and no latch is inferred.
    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = clr ? '0 : d;
        end
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule : flopenrc

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage with the IF/ID pipeline register.
// Holds the PC, applies Decode-resolved redirects and counts accepted instructions.
module fetch_stage
    import mips_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);

    logic [WIDTH-1:0]     pc;
    logic [WIDTH-1:0]     pcplus4F;
    logic [WIDTH-1:0]     redirect_pc;
    logic [WIDTH-1:0]     pc_next;
    npc_sel_e             npc_sel;
    ifid_action_e         ifid_action;
    logic                 ifid_en;
    logic                 ifid_clr;
    logic [WIDTH-1:0]     instr_d;
    logic [WIDTH-1:0]     pcplus4_d;
    logic [WIDTH-1:0]     instr_q;
    logic [WIDTH-1:0]     pcplus4_q;
    logic                 valid_q;
    logic [CNT_WIDTH-1:0] fetch_cnt_d;
    logic [CNT_WIDTH-1:0] fetch_cnt_q;

    assign pcplus4F    = pc + WIDTH'(PC_INC);
    assign redirect_pc = {bus.redirect_target[WIDTH-1:2], 2'b00};

    // Stall outranks redirect: the branch stays in Decode and re-asserts redirect later.
    always_comb begin
        npc_sel     = NPC_INC;
        ifid_action = IFID_CAPTURE;
        if (bus.stall) begin
            npc_sel     = NPC_HOLD;
            ifid_action = IFID_HOLD;
        end else if (bus.redirect) begin
            npc_sel     = NPC_REDIRECT;
            ifid_action = IFID_FLUSH;
        end
    end

    always_comb begin
        pc_next = pcplus4F;
        case (npc_sel)
            NPC_REDIRECT: pc_next = redirect_pc;
            NPC_HOLD:     pc_next = pc;
            default:      pc_next = pcplus4F;
        endcase
    end

    assign ifid_en   = (ifid_action != IFID_HOLD);
    assign ifid_clr  = (ifid_action == IFID_FLUSH);
    assign instr_d   = bus.instr_i;
    assign pcplus4_d = pcplus4F;

    flopenrc #(.WIDTH(WIDTH), .RESET_VAL(RESET_PC)) u_pc_reg (
        .clk   (clk),
        .reset (reset),
        .en    (npc_sel != NPC_HOLD),
        .clr   (1'b0),
        .d     (pc_next),
        .q     (pc)
    );

    // A flush loads zero, which decodes as sll $0,$0,0 (a NOP).
    flopenrc #(.WIDTH(WIDTH), .RESET_VAL(WIDTH'(NOP_INSTR))) u_instr_reg (
        .clk   (clk),
        .reset (reset),
        .en    (ifid_en),
        .clr   (ifid_clr),
        .d     (instr_d),
        .q     (instr_q)
    );

    flopenrc #(.WIDTH(WIDTH), .RESET_VAL('0)) u_pcplus4_reg (
        .clk   (clk),
        .reset (reset),
        .en    (ifid_en),
        .clr   (ifid_clr),
        .d     (pcplus4_d),
        .q     (pcplus4_q)
    );

    flopenrc #(.WIDTH(1), .RESET_VAL(1'b0)) u_valid_reg (
        .clk   (clk),
        .reset (reset),
        .en    (ifid_en),
        .clr   (ifid_clr),
        .d     (1'b1),
        .q     (valid_q)
    );

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        if (ifid_action == IFID_CAPTURE) begin
            fetch_cnt_d = fetch_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign bus.pcF       = pc;
    assign bus.instrD    = instr_q;
    assign bus.pcplus4D  = pcplus4_q;
    assign bus.opD       = instr_q[OP_MSB:OP_LSB];
    assign bus.functD    = instr_q[FUNCT_MSB:FUNCT_LSB];
    assign bus.validD    = valid_q;
    assign bus.fetch_cnt = fetch_cnt_q;

endmodule : fetch_stage
